// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Consumer end of the 49.152 MHz system PLL. Qualifies the asynchronous PLL
// locked flag, holds the game core in reset until the clock has been stable
// for HOLD_CYCLES cycles, and then generates the phase-aligned clock enables
// the core runs on (pixel = clk_sys/PIX_DIV, CPU = clk_sys/CPU_DIV). The core
// is put back into reset as soon as lock is lost.
//
// Ports:
//   clk_sys    in   PLL output clock (49.152 MHz)
//   reset      in   synchronous active-high user/OSD reset
//   pll_locked in   PLL locked flag, asynchronous to clk_sys
//   core_reset out  active-high reset to the game core
//   ready      out  high while the core is running
//   ce_pix     out  1-cycle enable every PIX_DIV cycles
//   ce_cpu     out  1-cycle enable every CPU_DIV cycles
//   ce_cpu_n   out  1-cycle enable CPU_DIV/2 cycles away from ce_cpu
//   lock_lost  out  sticky: lock dropped while running, cleared by reset
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4096,
  parameter int PIX_DIV     = 8,
  parameter int CPU_DIV     = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
  output logic core_reset,
  output logic ready,
  output logic ce_pix,
  output logic ce_cpu,
  output logic ce_cpu_n,
  output logic lock_lost
);

  localparam int DIV_W = $clog2(CPU_DIV);
  localparam int PIX_W = $clog2(PIX_DIV);

  localparam logic [15:0]      HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] CPU_LAST  = DIV_W'(CPU_DIV - 1);
  localparam logic [DIV_W-1:0] CPU_HALF  = DIV_W'(CPU_DIV / 2 - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [15:0]            hold_q, hold_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   core_reset_q, core_reset_d;
  logic                   ready_q, ready_d;
  logic                   ce_pix_q, ce_pix_d;
  logic                   ce_cpu_q, ce_cpu_d;
  logic                   ce_cpu_n_q, ce_cpu_n_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   lk_s;

  // Only the last synchronizer stage is safe to use downstream.
  assign lk_s = sync_q[SYNC_STAGES-1];

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    lock_lost_d = lock_lost_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], pll_locked};

    unique case (state_q)
      WAIT_LOCK: begin
        hold_d = '0;
        if (lk_s) state_d = HOLD;
      end
      HOLD: begin
        if (!lk_s) begin
          // Any low pulse restarts the stability interval from zero.
          state_d = WAIT_LOCK;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else if (hold_q != 16'hFFFF) begin
          hold_d = hold_q + 16'd1;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d     = WAIT_LOCK;
          lock_lost_d = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Outputs are registered from the next state so core_reset follows the
    // state change on the same edge and is glitch-free.
    core_reset_d = (state_d != RUN);
    ready_d      = (state_d == RUN);

    // Divider sits at zero through reset so the first enable lands a full
    // period after release, phase-aligned to the core.
    div_d = core_reset_q ? '0 : div_q + DIV_W'(1);

    ce_pix_d   = !core_reset_d && (div_q[PIX_W-1:0] == PIX_LAST);
    ce_cpu_d   = !core_reset_d && (div_q == CPU_LAST);
    ce_cpu_n_d = !core_reset_d && (div_q == CPU_HALF);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      sync_q       <= '0;
      hold_q       <= '0;
      div_q        <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      ce_pix_q     <= 1'b0;
      ce_cpu_q     <= 1'b0;
      ce_cpu_n_q   <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      hold_q       <= hold_d;
      div_q        <= div_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
      ce_pix_q     <= ce_pix_d;
      ce_cpu_q     <= ce_cpu_d;
      ce_cpu_n_q   <= ce_cpu_n_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign ce_pix     = ce_pix_q;
  assign ce_cpu     = ce_cpu_q;
  assign ce_cpu_n   = ce_cpu_n_q;
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Scoreboard bench. Stimulus pushes expected events (core_reset edges and
// enable pulses, each tagged with the clk_sys cycle it must appear on) into
// a queue; a monitor on the falling edge detects events from the DUT and
// pops/compares them in order. Cycle n means "changed on rising edge n".
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int PIX  = 8;
  localparam int CPU  = 16;

  typedef enum int {EV_REL, EV_ASRT, EV_PIX, EV_CPU, EV_CPUN} ev_kind_e;

  typedef struct {
    ev_kind_e kind;
    int       cyc;
    logic     lost;
    string    name;
  } exp_t;

  logic clk_sys = 1'b0;
  logic reset;
  logic pll_locked;
  logic core_reset, ready, ce_pix, ce_cpu, ce_cpu_n, lock_lost;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   watch_lo = 1;
  int   watch_hi = 0;
  logic prev_cr = 1'b1;
  exp_t sb[$];

  pll_lock_sequencer #(
    .SYNC_STAGES(SYNC),
    .HOLD_CYCLES(HOLD),
    .PIX_DIV    (PIX),
    .CPU_DIV    (CPU)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pll_locked(pll_locked),
    .core_reset(core_reset),
    .ready     (ready),
    .ce_pix    (ce_pix),
    .ce_cpu    (ce_cpu),
    .ce_cpu_n  (ce_cpu_n),
    .lock_lost (lock_lost)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input string act,
                       input string exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e k, input int c, input logic lost,
                      input string nm);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.lost = lost;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Expected enable pulses for the len cycles after release at cycle r,
  // in the monitor's per-cycle order: pix, cpu, cpu_n.
  task automatic push_ce(input int r, input int len, input string tag);
    for (int d = 1; d <= len; d++) begin
      if (d % PIX == 0)       push(EV_PIX,  r + d, 1'b0, $sformatf("%s_pix_%0d", tag, d));
      if (d % CPU == 0)       push(EV_CPU,  r + d, 1'b0, $sformatf("%s_cpu_%0d", tag, d));
      if (d % CPU == CPU / 2) push(EV_CPUN, r + d, 1'b0, $sformatf("%s_cpun_%0d", tag, d));
    end
  endtask

  task automatic observe(input ev_kind_e k);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", 1'b0, $sformatf("%s@%0d", k.name(), cyc), "no event");
      return;
    end
    e = sb.pop_front();
    check(e.name, (k == e.kind) && (cyc == e.cyc),
          $sformatf("%s@%0d", k.name(), cyc), $sformatf("%s@%0d", e.kind.name(), e.cyc));
    if (k == EV_REL || k == EV_ASRT) begin
      check({e.name, "_lock_lost"}, lock_lost === e.lost,
            $sformatf("%b", lock_lost), $sformatf("%b", e.lost));
      check({e.name, "_ready"}, ready === (k == EV_REL),
            $sformatf("%b", ready), $sformatf("%b", (k == EV_REL)));
    end
  endtask

  // Monitor: detect DUT events away from the active edge.
  always @(negedge clk_sys) begin
    if (cyc >= 1) begin
      if (core_reset === 1'b1)
        check($sformatf("ce_gated_%0d", cyc), !(ce_pix || ce_cpu || ce_cpu_n),
              $sformatf("%b%b%b", ce_pix, ce_cpu, ce_cpu_n), "000");
      if (core_reset !== prev_cr) begin
        observe(core_reset ? EV_ASRT : EV_REL);
        prev_cr = core_reset;
      end
      if (cyc >= watch_lo && cyc <= watch_hi) begin
        if (ce_pix)   observe(EV_PIX);
        if (ce_cpu)   observe(EV_CPU);
        if (ce_cpu_n) observe(EV_CPUN);
      end
    end
  end

  // Advance to 1 time unit after rising edge t.
  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset      = 1'b1;
    pll_locked = 1'b0;

    // Reset state after three reset cycles.
    at(3);
    check("rst_core_reset", core_reset === 1'b1, $sformatf("%b", core_reset), "1");
    check("rst_ready",      ready === 1'b0,      $sformatf("%b", ready),      "0");
    check("rst_lock_lost",  lock_lost === 1'b0,  $sformatf("%b", lock_lost),  "0");
    check("rst_ce", {ce_pix, ce_cpu, ce_cpu_n} === 3'b000,
          $sformatf("%b%b%b", ce_pix, ce_cpu, ce_cpu_n), "000");

    // 1. Power-up: release 2+1+16 = 19 cycles after reset is released.
    reset      = 1'b0;
    pll_locked = 1'b1;
    push(EV_REL, 22, 1'b0, "pwrup_release");

    // 2. Enable cadence over 64 cycles after release at 22.
    push_ce(22, 64, "cad");
    watch_lo = 23;
    watch_hi = 86;

    // 4. Lock loss in RUN: lk_s falls at 92, core_reset at 93.
    at(90);
    pll_locked = 1'b0;
    push(EV_ASRT, 93, 1'b1, "loss_assert");
    watch_lo = 93;   // no enables may appear until the relock release
    watch_hi = 119;
    at(100);
    pll_locked = 1'b1;
    push(EV_REL, 119, 1'b1, "relock_release");

    // 5. One-cycle reset mid-RUN sampled at 131; sync restarts, release 150.
    at(130);
    reset = 1'b1;
    at(131);
    reset = 1'b0;
    push(EV_ASRT, 131, 1'b0, "midrun_reset_assert");
    push(EV_REL, 150, 1'b0, "midrun_reset_release");
    push_ce(150, 16, "restart");
    watch_lo = 151;
    watch_hi = 166;

    // 3. HOLD glitch: reset at 181, HOLD from 184, lk_s low only at 195,
    //    WAIT_LOCK at 196, HOLD again at 197, release at 197+16 = 213.
    at(180);
    reset = 1'b1;
    at(181);
    reset = 1'b0;
    push(EV_ASRT, 181, 1'b0, "glitch_reset_assert");
    at(193);
    pll_locked = 1'b0;
    at(194);
    pll_locked = 1'b1;
    push(EV_REL, 213, 1'b0, "glitch_release");

    // 6. Reset on the same edge (233) that sees lk_s fall in RUN.
    at(230);
    pll_locked = 1'b0;
    at(232);
    reset = 1'b1;
    at(233);
    reset = 1'b0;
    push(EV_ASRT, 233, 1'b0, "race_assert");
    // Stays in WAIT_LOCK until relock at 260; release at 279, lock_lost 0.
    at(260);
    pll_locked = 1'b1;
    push(EV_REL, 279, 1'b0, "race_relock_release");

    at(300);
    check("scoreboard_drained", sb.size() == 0, $sformatf("%0d left", sb.size()), "0 left");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.name, "_missing"}, 1'b0, "no event", $sformatf("%s@%0d", e.kind.name(), e.cyc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name:
pll_lock_sequencer

Overview:
- Consumer end of the 49.152 MHz system PLL. Runs in the PLL output domain and receives the PLL `locked` flag.
- Qualifies `locked` and holds the core in reset until the clock has been stable for a programmable time.
- Generates the phase-aligned clock enables the Time Pilot core runs on: pixel 6.144 MHz, CPU 3.072 MHz.
- Re-asserts core reset whenever lock is lost.

Parameters:
- SYNC_STAGES, 2, flops in the `locked` synchronizer chain (min 2).
- HOLD_CYCLES, 4096, consecutive synchronized-locked cycles required before releasing reset (min 1, max 65535).
- PIX_DIV, 8, clk_sys cycles per ce_pix pulse (power of two, ≥2).
- CPU_DIV, 16, clk_sys cycles per ce_cpu pulse (multiple of PIX_DIV, power of two).

Ports:
- clk_sys  in  1  49.152 MHz PLL output clock.
- reset  in  1  synchronous active-high reset (user/OSD reset).
- pll_locked  in  1  PLL locked flag, asynchronous to clk_sys.
- core_reset  out  1  active-high reset to the game core.
- ready  out  1  high in RUN state.
- ce_pix  out  1  1-cycle enable every PIX_DIV cycles.
- ce_cpu  out  1  1-cycle enable every CPU_DIV cycles.
- ce_cpu_n  out  1  1-cycle enable offset CPU_DIV/2 from ce_cpu (falling-phase enable).
- lock_lost  out  1  sticky: lock dropped while in RUN; cleared only by reset.

Behaviour:
- Synchronizer: pll_locked passes through SYNC_STAGES flops → lk_s. Only lk_s is used downstream.
- On reset=1 (synchronous):
  - state=WAIT_LOCK, hold counter=0, divider counter=0, lock_lost=0.
  - Synchronizer flops cleared.
  - Outputs: core_reset=1, ready=0, ce_pix=ce_cpu=ce_cpu_n=0.
- States:
  - WAIT_LOCK: core_reset=1, hold counter=0. lk_s=1 → HOLD.
  - HOLD: core_reset=1. Counter increments each cycle while lk_s=1. lk_s=0 → WAIT_LOCK, counter cleared. When counter reaches HOLD_CYCLES-1 with lk_s=1 → RUN on the next edge.
  - RUN: core_reset=0, ready=1. lk_s=0 → WAIT_LOCK and lock_lost←1 on that same edge. core_reset is high in the first WAIT_LOCK cycle.
- Latency:
  - From pll_locked rise (stable) to core_reset fall is exactly SYNC_STAGES+1+HOLD_CYCLES clk_sys cycles, ±1 for asynchronous sampling.
  - From lk_s fall in RUN to core_reset=1 is 1 cycle.
- Divider: single free-running counter of width log2(CPU_DIV).
  - Held at 0 while core_reset=1; runs while core_reset=0.
  - ce_pix=1 when count[log2(PIX_DIV)-1:0]==PIX_DIV-1.
  - ce_cpu=1 when count==CPU_DIV-1.
  - ce_cpu_n=1 when count==CPU_DIV/2-1.
  - All enables are registered and never asserted while core_reset=1.
  - First ce_pix occurs PIX_DIV cycles after core_reset falls. First ce_cpu occurs CPU_DIV cycles after. ce_cpu always coincides with a ce_pix.
- Wrap: the counter wraps CPU_DIV-1 → 0 with no dropped or doubled pulse.
- Hold counter width is 16 bits and it saturates, never wraps.
- Glitch: an lk_s low pulse of any width ≥1 cycle in HOLD restarts the hold interval from zero.
- Simultaneous reset=1 and any lock event: reset wins, and lock_lost stays 0.
- Reset mid-RUN: returns to WAIT_LOCK. If lk_s is still 1, HOLD is re-entered the cycle after reset deasserts and a full HOLD_CYCLES is re-served.
- lock_lost is never set by a lock drop in WAIT_LOCK or HOLD.

Test Plan:
1. Power-up (HOLD_CYCLES=16): reset 3 cycles, then pll_locked=1 constant → core_reset falls at cycle 2+1+16=19±1 after reset release, ready=1, lock_lost=0.
2. Enable cadence in RUN over 64 cycles:
   - ce_pix pulses every 8 cycles, ce_cpu every 16 cycles.
   - ce_cpu_n falls 8 cycles after each ce_cpu.
   - Each ce_cpu coincides with ce_pix; all pulses are 1 cycle wide.
3. HOLD glitch: pll_locked low for 1 cycle after 10 HOLD cycles → core_reset stays 1, and release happens a full 16 cycles after lk_s returns.
4. Lock loss in RUN: drop pll_locked → core_reset=1 and ready=0 SYNC_STAGES+1 cycles later; enables stop; lock_lost=1. Relock → release after the full hold again, with lock_lost still 1.
5. Reset mid-RUN with pll_locked=1: pulse reset for 1 cycle → core_reset=1 immediately, lock_lost=0, re-release after 16 HOLD cycles, divider restarts (first ce_pix 8 cycles after release).
6. Reset asserted on the same edge lk_s falls in RUN → lock_lost remains 0 and state=WAIT_LOCK.
